// File: rtl/base_acredit_snk.sv
// Credit-link sink: buffers beats pushed by a credit source, hands them downstream
// on valid/ready and returns one single-cycle credit pulse per dequeued beat.
module base_acredit_snk #(
  parameter int credits     = 4,
  parameter int width       = 8,
  parameter int log_credits = $clog2(credits + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_v,
  input  logic [width-1:0]       i_d,
  output logic                   o_v,
  input  logic                   o_r,
  output logic [width-1:0]       o_d,
  output logic                   o_c,
  output logic [log_credits-1:0] o_cnt,
  output logic                   o_err
);

  localparam int ptr_w = (credits > 1) ? $clog2(credits) : 1;
  localparam logic [ptr_w-1:0]       last_ptr = ptr_w'(credits - 1);
  localparam logic [log_credits-1:0] full_cnt = log_credits'(credits);

  logic [width-1:0]       mem [credits];
  logic [ptr_w-1:0]       wr_ptr;
  logic [ptr_w-1:0]       rd_ptr;
  logic [log_credits-1:0] count;
  logic                   full;
  logic                   enq;
  logic                   deq;
  logic                   ovf;

  // A full buffer means the source had no credit; that beat is a protocol error, never stored.
  assign full  = (count == full_cnt);
  assign enq   = i_v && !full;
  assign ovf   = i_v && full;
  assign deq   = o_v && o_r;
  assign o_v   = (count != '0);
  assign o_d   = mem[rd_ptr];
  assign o_cnt = count;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (p == last_ptr) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage sits outside the reset domain; o_v gates its contents, and leaving
  // it unreset lets it map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= i_d;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_c    <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      if (enq) wr_ptr <= next_ptr(wr_ptr);
      if (deq) rd_ptr <= next_ptr(rd_ptr);
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      o_c   <= deq;
      o_err <= o_err | ovf;
    end
  end

endmodule

// File: tb/tb_base_acredit_snk.sv
// Randomized bench for base_acredit_snk: a credits=4 and a credits=3 instance checked
// against queue-based reference models and a behavioural credit source.
module tb_base_acredit_snk;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       a_iv, a_or, a_ov, a_oc, a_err;
  logic [7:0] a_id, a_od;
  logic [2:0] a_cnt;
  logic       b_iv, b_or, b_ov, b_oc, b_err;
  logic [7:0] b_id, b_od;
  logic [1:0] b_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic       ea_c = 1'b0, ea_err = 1'b0;
  logic       eb_c = 1'b0, eb_err = 1'b0;

  base_acredit_snk #(.credits(4), .width(8)) dut_a (
    .clk(clk), .reset(reset), .i_v(a_iv), .i_d(a_id), .o_v(a_ov), .o_r(a_or),
    .o_d(a_od), .o_c(a_oc), .o_cnt(a_cnt), .o_err(a_err)
  );

  base_acredit_snk #(.credits(3), .width(8)) dut_b (
    .clk(clk), .reset(reset), .i_v(b_iv), .i_d(b_id), .o_v(b_ov), .o_r(b_or),
    .o_d(b_od), .o_c(b_oc), .o_cnt(b_cnt), .o_err(b_err)
  );

  // Observed and expected status: {valid, credit, err, count, head-or-zero}.
  function automatic logic [13:0] st_a();
    return {a_ov, a_oc, a_err, a_cnt, a_ov ? a_od : 8'h00};
  endfunction
  function automatic logic [13:0] exp_a();
    logic ne = (qa.size() != 0);
    return {ne, ea_c, ea_err, 3'(qa.size()), ne ? qa[0] : 8'h00};
  endfunction
  function automatic logic [12:0] st_b();
    return {b_ov, b_oc, b_err, b_cnt, b_ov ? b_od : 8'h00};
  endfunction
  function automatic logic [12:0] exp_b();
    logic ne = (qb.size() != 0);
    return {ne, eb_c, eb_err, 2'(qb.size()), ne ? qb[0] : 8'h00};
  endfunction

  task automatic clear_models();
    qa.delete();
    qb.delete();
    ea_c = 1'b0; ea_err = 1'b0;
    eb_c = 1'b0; eb_err = 1'b0;
  endtask

  task automatic idle_all();
    a_iv = 1'b0; a_or = 1'b0; a_id = 8'h00;
    b_iv = 1'b0; b_or = 1'b0; b_id = 8'h00;
  endtask

  // One clock: the models apply the buffer rules to the inputs seen at the edge.
  task automatic step();
    logic dq, eq;
    @(posedge clk);
    dq = (qa.size() != 0) && a_or;
    eq = a_iv && (qa.size() < 4);
    ea_err = ea_err | (a_iv && (qa.size() == 4));
    ea_c = dq;
    if (dq) void'(qa.pop_front());
    if (eq) qa.push_back(a_id);
    dq = (qb.size() != 0) && b_or;
    eq = b_iv && (qb.size() < 3);
    eb_err = eb_err | (b_iv && (qb.size() == 3));
    eb_c = dq;
    if (dq) void'(qb.pop_front());
    if (eq) qb.push_back(b_id);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (st_a() !== 14'h0) begin
      errors++; $display("FAIL reset_a: got %h expected %h", st_a(), 14'h0);
    end
    checks++;
    if (st_b() !== 13'h0) begin
      errors++; $display("FAIL reset_b: got %h expected %h", st_b(), 13'h0);
    end
  endtask

  task automatic test_single_beat();
    a_iv = 1'b1; a_id = 8'hA5; a_or = 1'b1;
    step();
    checks++;
    if (a_ov !== 1'b1 || a_od !== 8'hA5 || st_a() !== exp_a()) begin
      errors++; $display("FAIL single_visible: got %h expected %h", st_a(), exp_a());
    end
    a_iv = 1'b0;
    step();
    checks++;
    if (a_oc !== 1'b1 || a_cnt !== 3'd0 || st_a() !== exp_a()) begin
      errors++; $display("FAIL single_credit: got %h expected %h", st_a(), exp_a());
    end
    a_or = 1'b0;
    step();
    checks++;
    if (a_oc !== 1'b0 || st_a() !== exp_a()) begin
      errors++; $display("FAIL single_pulse_width: got %h expected %h", st_a(), exp_a());
    end
  endtask

  // Fill to 4 with o_r low, optionally send an overflow beat, then drain.
  task automatic fill_drain(input bit overflow);
    logic [7:0] got[$];
    idle_all();
    for (int i = 1; i <= 4; i++) begin
      a_iv = 1'b1; a_id = 8'(i);
      step();
      checks++;
      if (st_a() !== exp_a()) begin
        errors++; $display("FAIL fill_%0d: got %h expected %h", i, st_a(), exp_a());
      end
    end
    a_iv = 1'b0;
    checks++;
    if (a_cnt !== 3'd4 || a_ov !== 1'b1 || a_od !== 8'h01 || a_oc !== 1'b0) begin
      errors++; $display("FAIL full_state: got cnt=%0d v=%b d=%h c=%b expected cnt=4 v=1 d=01 c=0",
                         a_cnt, a_ov, a_od, a_oc);
    end
    if (overflow) begin
      a_iv = 1'b1; a_id = 8'hFF;
      step();
      checks++;
      if (a_err !== 1'b1 || a_cnt !== 3'd4 || st_a() !== exp_a()) begin
        errors++; $display("FAIL overflow: got %h expected %h", st_a(), exp_a());
      end
      a_or = 1'b1;
      if (a_ov && a_or) got.push_back(a_od);
      step();
      checks++;
      if (a_err !== 1'b1 || a_cnt !== 3'd3 || a_oc !== 1'b1 || st_a() !== exp_a()) begin
        errors++; $display("FAIL overflow_with_deq: got %h expected %h", st_a(), exp_a());
      end
      a_iv = 1'b0;
    end
    a_or = 1'b1;
    while (got.size() < 4 && a_ov) begin
      got.push_back(a_od);
      step();
      checks++;
      if (st_a() !== exp_a() || a_oc !== 1'b1) begin
        errors++; $display("FAIL drain: got %h expected %h", st_a(), exp_a());
      end
    end
    a_or = 1'b0;
    step();
    checks++;
    if (got.size() != 4 || a_cnt !== 3'd0 || a_oc !== 1'b0 || a_err !== overflow) begin
      errors++; $display("FAIL drain_end: got n=%0d cnt=%0d c=%b err=%b expected n=4 cnt=0 c=0 err=%b",
                         got.size(), a_cnt, a_oc, a_err, overflow);
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(i + 1)) begin
        errors++; $display("FAIL drain_order_%0d: got %h expected %h", i, got[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_fill_drain();
    fill_drain(1'b0);
  endtask

  task automatic test_overflow();
    fill_drain(1'b1);
  endtask

  task automatic test_steady_stream();
    idle_all();
    for (int i = 0; i < 2; i++) begin
      a_iv = 1'b1; a_id = 8'($urandom);
      step();
    end
    a_or = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a_id = 8'($urandom);
      step();
      checks++;
      if (a_cnt !== 3'd2 || a_oc !== 1'b1 || st_a() !== exp_a()) begin
        errors++; $display("FAIL steady_%0d: got %h expected %h", i, st_a(), exp_a());
      end
    end
    a_iv = 1'b0;
    repeat (4) step();
    a_or = 1'b0;
    step();
    checks++;
    if (st_a() !== exp_a() || a_cnt !== 3'd0) begin
      errors++; $display("FAIL steady_drain: got %h expected %h", st_a(), exp_a());
    end
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int popped = 0;
    idle_all();
    for (int cyc = 0; cyc < 300 && popped < 10; cyc++) begin
      b_iv = (pushed < 10) && (qb.size() < 3) && ($urandom_range(0, 3) != 0);
      b_id = 8'($urandom);
      b_or = ($urandom_range(0, 1) != 0);
      if (b_iv) pushed++;
      if (b_ov && b_or) popped++;
      step();
      checks++;
      if (st_b() !== exp_b() || b_cnt > 2'd3 || b_err !== 1'b0) begin
        errors++; $display("FAIL wrap_%0d: got %h expected %h", cyc, st_b(), exp_b());
      end
    end
    idle_all();
    checks++;
    if (pushed != 10 || popped != 10) begin
      errors++; $display("FAIL wrap_timeout: got pushed=%0d popped=%0d expected 10/10", pushed, popped);
    end
  endtask

  // Behavioural credit source in a zero-latency loop; reset lands mid-burst.
  task automatic test_loopback();
    int  src_cred = 4;
    int  late_deq = 0;
    logic oc_pre;
    logic sent;
    clear_err_for_loopback();
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc < 60) begin
        a_iv = (src_cred > 0) && ($urandom_range(0, 2) != 0);
        a_or = ($urandom_range(0, 2) != 0);
      end else begin
        a_iv = (src_cred > 0);
        a_or = 1'b1;
      end
      a_id = 8'($urandom);
      sent = a_iv;
      oc_pre = a_oc;
      if (cyc >= 72 && a_ov && a_or) late_deq++;
      step();
      src_cred = src_cred - int'(sent) + int'(oc_pre);
      checks++;
      if (st_a() !== exp_a() || a_err !== 1'b0 || src_cred + int'(a_cnt) + int'(a_oc) != 4) begin
        errors++; $display("FAIL loop_%0d: got %h expected %h src_cred=%0d", cyc, st_a(), exp_a(), src_cred);
      end
      if (cyc == 30) begin
        #2 reset = 1'b0;
        #1;
        checks++;
        if (a_ov !== 1'b0 || a_cnt !== 3'd0 || a_oc !== 1'b0 || a_err !== 1'b0) begin
          errors++; $display("FAIL mid_reset: got v=%b cnt=%0d c=%b err=%b expected all 0",
                             a_ov, a_cnt, a_oc, a_err);
        end
        clear_models();
        src_cred = 4;
        @(negedge clk);
        reset = 1'b1;
        #1;
      end
    end
    idle_all();
    checks++;
    if (late_deq != 8) begin
      errors++; $display("FAIL loop_throughput: got %0d beats in 8 cycles expected 8", late_deq);
    end
  endtask

  // The overflow test leaves o_err sticky; a clean reset restores both ends.
  task automatic clear_err_for_loopback();
    idle_all();
    reset = 1'b0;
    #3;
    clear_models();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (st_a() !== 14'h0) begin
      errors++; $display("FAIL err_clear: got %h expected %h", st_a(), 14'h0);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_all();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    test_reset();
    test_single_beat();
    test_fill_drain();
    test_steady_stream();
    test_wrap();
    test_overflow();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
